pc_branch_predictor: RTL
========================

Name: pc_branch_predictor

Overview:
Parametrised fetch-stage next-PC unit for the 5-stage RV32I pipeline.
- Owns the PC register.
- Predicts branches and JAL in Fetch using a direct-mapped BTB with 2-bit saturating counters.
- Resolves the real outcome from Execute and redirects or flushes on mispredict, raising Hazard_PCsrc towards the hazard unit.
- Supersedes the purely combinational PC-source mux: adds state, prediction and full condition handling.

Parameters:
DATA_WIDTH, 32, address/data width.
BTB_ENTRIES, 64, BTB depth; power of two, min 2; IDX = log2(BTB_ENTRIES).
RESET_PC, 0, PCF value after reset.

Ports:
clk  in  1  clock, all state on rising edge.
rst_n  in  1  synchronous active-low reset.
StallF  in  1  hold PCF (hazard unit).
PCF  out  DATA_WIDTH  current fetch PC.
PCPlus4F  out  DATA_WIDTH  PCF+4.
PredTakenF  out  1  Fetch predicts taken for PCF.
PredTargetF  out  DATA_WIDTH  predicted target, valid when PredTakenF=1, else PCPlus4F.
ValidE  in  1  Execute holds a real (non-bubble) instruction.
BranchE  in  1  conditional branch in E.
JumpE  in  1  JAL in E.
JalrE  in  1  JALR in E.
TakenE  in  1  resolved branch condition (ALU compare, all six B-types).
PCE  in  DATA_WIDTH  PC of E instruction.
PCTargetE  in  DATA_WIDTH  PCE+ImmExt.
ALUResultE  in  DATA_WIDTH  JALR target before LSB clear.
PredTakenE  in  1  PredTakenF piped to E.
PredTargetE  in  DATA_WIDTH  PredTargetF piped to E.
Hazard_PCsrc  out  1  redirect this cycle; flush D and E.
RedirectPC  out  DATA_WIDTH  corrected next PC (valid with Hazard_PCsrc).

Behaviour:
- Reset (rst_n=0 at edge): PCF=RESET_PC; all BTB valid bits=0; all counters=2'b01. Hazard_PCsrc combinational, 0 while ValidE=0.
- BTB entry: valid, tag=PC[DATA_WIDTH-1:IDX+2], target, ctr[1:0]. Index = PC[IDX+1:2].
- Fetch lookup is combinational on PCF. Hit = valid & tag match. PredTakenF = hit & ctr[1]. PredTargetF = PredTakenF ? entry target : PCPlus4F.
- Resolution (comb, only when ValidE=1):
  - JALR: actual target = ALUResultE & ~1; always mispredicts (never predicted).
  - JAL: actual taken=1, target=PCTargetE.
  - Branch: taken=TakenE, target=PCTargetE.
  - Non-control: taken=0.
  - Mispredict if actual taken != PredTakenE, or (both taken and PredTargetE != actual target).
  - RedirectPC = actual taken ? target : PCE+4.
  - Hazard_PCsrc = mispredict.
- PC update priority: reset > Hazard_PCsrc (PCF<=RedirectPC, overrides StallF) > StallF (hold) > PredTargetF.
- BTB update at edge when ValidE & (BranchE|JumpE):
  - Counter saturating: +1 if taken, max 3; -1 if not, min 0. JAL forces 3.
  - If taken: write valid=1, tag, target. If tag mismatched, ctr = taken ? 2 : 1 (new allocation).
  - Not taken with tag mismatch: no write.
  - JALR never updates.
- Simultaneous Fetch read and E update of same index: Fetch sees pre-update contents (read-before-write).
- Mid-operation reset: reset wins over redirect and update; table fully invalidated in one cycle.
- All address arithmetic modulo 2^DATA_WIDTH; PCE+4 wraps silently.

Optional Feature:
BP_STATS_EN. When defined, adds outputs BranchCount and MispredictCount, each 32-bit saturating (stick at 0xFFFFFFFF), reset to 0.
- BranchCount increments per ValidE & (BranchE|JumpE|JalrE).
- MispredictCount increments per Hazard_PCsrc.
When undefined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset with RESET_PC=0x0: hold rst_n=0 two cycles, release -> PCF=0x0, then 0x4, 0x8; PredTakenF=0; Hazard_PCsrc=0.
- Backward loop: BEQ at 0x10 targeting 0x4, TakenE=1 three times.
  - First resolution -> Hazard_PCsrc=1, RedirectPC=0x4; entry ctr=2.
  - Next fetch of 0x10 -> PredTakenF=1, PredTargetF=0x4; second resolution with PredTakenE=1 -> no flush.
- Loop exit: counter=3, BEQ resolves TakenE=0 with PredTakenE=1 -> Hazard_PCsrc=1, RedirectPC=0x14, ctr=2.
- JALR: PCE=0x40, ALUResultE=0x1235 -> Hazard_PCsrc=1, next PCF=0x1234; BTB unchanged.
- Redirect vs stall: StallF=1 and mispredict in same cycle -> PCF takes RedirectPC. StallF=1 alone -> PCF held.
- Alias: BTB_ENTRIES=4, taken branches at 0x10 and 0x20 (same index) -> second allocation overwrites tag. Fetch of 0x10 -> PredTakenF=0.

Source files
------------

// File: rtl/pc_branch_predictor.sv
// Fetch-stage next-PC unit: PC register, direct-mapped BTB with 2-bit counters, Execute-stage resolution.
// Optional BP_STATS_EN adds saturating branch/mispredict counters.

module pc_bp_btb_entry #(
  parameter int TAG_W      = 26,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_ctr,
  input  logic                  we_line,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_target,
  input  logic [1:0]            wr_ctr,
  output logic                  valid,
  output logic [TAG_W-1:0]      tag,
  output logic [DATA_WIDTH-1:0] target,
  output logic [1:0]            ctr
);
  logic                  valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic [DATA_WIDTH-1:0] target_q, target_d;
  logic [1:0]            ctr_q, ctr_d;

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    if (we_line) begin
      valid_d  = 1'b1;
      tag_d    = wr_tag;
      target_d = wr_target;
    end
    if (we_ctr) ctr_d = wr_ctr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      tag_q    <= '0;
      target_q <= '0;
      ctr_q    <= 2'b01;
    end else begin
      valid_q  <= valid_d;
      tag_q    <= tag_d;
      target_q <= target_d;
      ctr_q    <= ctr_d;
    end
  end

  assign valid  = valid_q;
  assign tag    = tag_q;
  assign target = target_q;
  assign ctr    = ctr_q;
endmodule

module pc_branch_predictor #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    BTB_ENTRIES = 64,
  parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallF,
  output logic [DATA_WIDTH-1:0] PCF,
  output logic [DATA_WIDTH-1:0] PCPlus4F,
  output logic                  PredTakenF,
  output logic [DATA_WIDTH-1:0] PredTargetF,
  input  logic                  ValidE,
  input  logic                  BranchE,
  input  logic                  JumpE,
  input  logic                  JalrE,
  input  logic                  TakenE,
  input  logic [DATA_WIDTH-1:0] PCE,
  input  logic [DATA_WIDTH-1:0] PCTargetE,
  input  logic [DATA_WIDTH-1:0] ALUResultE,
  input  logic                  PredTakenE,
  input  logic [DATA_WIDTH-1:0] PredTargetE,
`ifdef BP_STATS_EN
  output logic [31:0]           BranchCount,
  output logic [31:0]           MispredictCount,
`endif
  output logic                  Hazard_PCsrc,
  output logic [DATA_WIDTH-1:0] RedirectPC
);
  localparam int IDX   = $clog2(BTB_ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX - 2;
  localparam logic [DATA_WIDTH-1:0] FOUR = DATA_WIDTH'(4);

  logic [DATA_WIDTH-1:0] pcf_q, pcf_d;

  logic [BTB_ENTRIES-1:0]                 ent_valid;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0]      ent_tag;
  logic [BTB_ENTRIES-1:0][DATA_WIDTH-1:0] ent_target;
  logic [BTB_ENTRIES-1:0][1:0]            ent_ctr;
  logic [BTB_ENTRIES-1:0]                 ent_we_ctr;
  logic [BTB_ENTRIES-1:0]                 ent_we_line;

  logic [IDX-1:0]        f_idx, e_idx;
  logic [TAG_W-1:0]      f_tag, e_tag;
  logic                  f_hit, e_hit;
  logic                  act_taken, mispredict, upd_en;
  logic [DATA_WIDTH-1:0] act_target;
  logic [1:0]            new_ctr;

  // Fetch lookup
  assign f_idx       = pcf_q[IDX+1:2];
  assign f_tag       = pcf_q[DATA_WIDTH-1:IDX+2];
  assign f_hit       = ent_valid[f_idx] && (ent_tag[f_idx] == f_tag);
  assign PCF         = pcf_q;
  assign PCPlus4F    = pcf_q + FOUR;
  assign PredTakenF  = f_hit && ent_ctr[f_idx][1];
  assign PredTargetF = PredTakenF ? ent_target[f_idx] : PCPlus4F;

  // Execute resolution; JALR is never in the BTB so it always redirects
  always_comb begin
    act_taken  = 1'b0;
    act_target = PCTargetE;
    mispredict = 1'b0;
    if (ValidE) begin
      if (JalrE) begin
        act_taken  = 1'b1;
        act_target = ALUResultE & ~FOUR[DATA_WIDTH-1:0] | (ALUResultE & ~DATA_WIDTH'(1) & FOUR);
        act_target = ALUResultE & ~DATA_WIDTH'(1);
      end else if (JumpE) begin
        act_taken = 1'b1;
      end else if (BranchE) begin
        act_taken = TakenE;
      end
      mispredict = JalrE || (act_taken != PredTakenE) ||
                   (act_taken && PredTakenE && (PredTargetE != act_target));
    end
  end

  assign Hazard_PCsrc = mispredict;
  assign RedirectPC   = act_taken ? act_target : PCE + FOUR;

  // BTB update from Execute
  assign e_idx  = PCE[IDX+1:2];
  assign e_tag  = PCE[DATA_WIDTH-1:IDX+2];
  assign e_hit  = ent_valid[e_idx] && (ent_tag[e_idx] == e_tag);
  assign upd_en = ValidE && (BranchE || JumpE) && !JalrE;

  always_comb begin
    new_ctr = ent_ctr[e_idx];
    if (JumpE)
      new_ctr = 2'd3;
    else if (!e_hit)
      new_ctr = act_taken ? 2'd2 : 2'd1;
    else if (act_taken)
      new_ctr = (ent_ctr[e_idx] == 2'd3) ? 2'd3 : ent_ctr[e_idx] + 2'd1;
    else
      new_ctr = (ent_ctr[e_idx] == 2'd0) ? 2'd0 : ent_ctr[e_idx] - 2'd1;
  end

  for (genvar i = 0; i < BTB_ENTRIES; i++) begin : g_btb
    logic sel;
    assign sel            = upd_en && (e_idx == IDX'(i));
    assign ent_we_line[i] = sel && act_taken;
    // a not-taken resolution only trains an entry that already belongs to this PC
    assign ent_we_ctr[i]  = sel && (act_taken || e_hit);

    pc_bp_btb_entry #(.TAG_W(TAG_W), .DATA_WIDTH(DATA_WIDTH)) u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .we_ctr    (ent_we_ctr[i]),
      .we_line   (ent_we_line[i]),
      .wr_tag    (e_tag),
      .wr_target (act_target),
      .wr_ctr    (new_ctr),
      .valid     (ent_valid[i]),
      .tag       (ent_tag[i]),
      .target    (ent_target[i]),
      .ctr       (ent_ctr[i])
    );
  end

  always_comb begin
    pcf_d = PredTargetF;
    if (Hazard_PCsrc)
      pcf_d = RedirectPC;
    else if (StallF)
      pcf_d = pcf_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pcf_q <= RESET_PC;
    else        pcf_q <= pcf_d;
  end

`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mp_cnt_q, mp_cnt_d;

  always_comb begin
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (ValidE && (BranchE || JumpE || JalrE) && (br_cnt_q != 32'hFFFF_FFFF))
      br_cnt_d = br_cnt_q + 32'd1;
    if (Hazard_PCsrc && (mp_cnt_q != 32'hFFFF_FFFF))
      mp_cnt_d = mp_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign BranchCount     = br_cnt_q;
  assign MispredictCount = mp_cnt_q;
`endif
endmodule
